// File: rtl/sysid_qsys_regs.sv
// sysid_qsys_regs: system-ID / build-info slave on the Avalon-MM control bus.
// Word map: ID, TIMESTAMP, VERSION, SCRATCH, UPTIME_LO, UPTIME_HI, CTRL, reserved.
// Reads return through a READ_LATENCY-deep pipeline with a readdatavalid pulse.
// Optional feature macro: SYSID_QSYS_UPTIME_EN adds the 64-bit uptime counter,
// its coherent high-word shadow and the CTRL register (FREEZE / CLEAR).
module sysid_qsys_regs #(
   parameter logic [31:0] SYSTEM_ID    = 32'h0400_0000,
   parameter logic [31:0] TIMESTAMP    = 32'h5451_44E7,
   parameter logic [31:0] VERSION      = 32'h0001_0000,
   parameter int          READ_LATENCY = 1,
   parameter int          ADDR_W       = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              readdatavalid
);

   localparam logic [2:0] A_ID      = 3'd0;
   localparam logic [2:0] A_TSTAMP  = 3'd1;
   localparam logic [2:0] A_VERSION = 3'd2;
   localparam logic [2:0] A_SCRATCH = 3'd3;
`ifdef SYSID_QSYS_UPTIME_EN
   localparam logic [2:0] A_UP_LO   = 3'd4;
   localparam logic [2:0] A_UP_HI   = 3'd5;
   localparam logic [2:0] A_CTRL    = 3'd6;
`endif

   // Reject unsupported configurations while elaborating.
   generate
      if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
         $error("sysid_qsys_regs: READ_LATENCY must be in 1..4");
      end
      if (ADDR_W < 3 || ADDR_W > 32) begin : g_bad_addr_w
         $error("sysid_qsys_regs: ADDR_W must be in 3..32");
      end
   endgenerate

   // Only the first eight words are decoded; anything above aliases to nothing.
   logic       w_in_map;
   logic [2:0] w_word;
   logic       w_scratch_we;
   logic [31:0] w_rdata;
   logic [31:0] r_scratch;

   assign w_in_map     = ((address >> 3) == '0);
   assign w_word       = address[2:0];
   assign w_scratch_we = write && w_in_map && (w_word == A_SCRATCH);

   // Scratch register: the written value is visible from the next cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_scratch <= '0;
      end else if (w_scratch_we) begin
         r_scratch <= writedata;
      end
   end

`ifdef SYSID_QSYS_UPTIME_EN
   logic [63:0] r_uptime;
   logic [31:0] r_hi_shadow;
   logic        r_freeze;
   logic        w_ctrl_we;
   logic        w_lo_rd;

   assign w_ctrl_we = write && w_in_map && (w_word == A_CTRL);
   assign w_lo_rd   = read && w_in_map && (w_word == A_UP_LO);

   // Uptime counter: CLEAR wins over the increment, FREEZE holds the value.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_uptime <= '0;
      end else if (w_ctrl_we && writedata[1]) begin
         r_uptime <= '0;
      end else if (!r_freeze) begin
         r_uptime <= r_uptime + 64'd1;
      end
   end

   // CTRL.FREEZE storage and the high-word snapshot taken on every LO read.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_freeze    <= 1'b0;
         r_hi_shadow <= '0;
      end else begin
         if (w_ctrl_we) begin
            r_freeze <= writedata[0];
         end
         if (w_lo_rd) begin
            r_hi_shadow <= r_uptime[63:32];
         end
      end
   end
`endif

   // Read mux: values as they stand in the cycle the read strobe is seen.
   always_comb begin
      w_rdata = '0;
      if (w_in_map) begin
         case (w_word)
            A_ID:      w_rdata = SYSTEM_ID;
            A_TSTAMP:  w_rdata = TIMESTAMP;
            A_VERSION: w_rdata = VERSION;
            A_SCRATCH: w_rdata = r_scratch;
`ifdef SYSID_QSYS_UPTIME_EN
            A_UP_LO:   w_rdata = r_uptime[31:0];
            A_UP_HI:   w_rdata = r_hi_shadow;
            A_CTRL:    w_rdata = {31'd0, r_freeze};
`endif
            default:   w_rdata = '0;
         endcase
      end
   end

   // Read pipeline: data is zeroed on idle slots so readdata is 0 whenever
   // readdatavalid is low, with no output gating needed.
   logic        r_vld [0:READ_LATENCY-1];
   logic [31:0] r_dat [0:READ_LATENCY-1];

   // Shift the read results one stage per clock; reset drops all in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_vld[i] <= 1'b0;
            r_dat[i] <= '0;
         end
      end else begin
         r_vld[0] <= read;
         r_dat[0] <= read ? w_rdata : 32'd0;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_dat[i] <= r_dat[i-1];
         end
      end
   end

   assign readdata      = r_dat[READ_LATENCY-1];
   assign readdatavalid = r_vld[READ_LATENCY-1];

endmodule
